comm_frame_rx: RTL and testbench
================================

Name: comm_frame_rx

Overview:
- Quadcopter-side command deframer; sits directly downstream of the UART receiver that terminates the link from the remote command master.
- Assembles each 3-byte frame (cmd, data[15:8], data[7:0]) into a command word for the flight command handler.
- Pushes the handler's single-byte response back out through the UART transmitter.
- Uses byte-level handshakes only; contains no UART.

Parameters:
- TIMEOUT_CYCLES, 100000: max clk cycles allowed between bytes of one frame. Used only with FRAME_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- rx_rdy  input  1  UART receiver holds a valid byte
- rx_data  input  8  received byte
- clr_rx_rdy  output  1  combinational; consumes the current rx byte
- cmd  output  8  assembled command byte
- data  output  16  assembled data word
- cmd_rdy  output  1  registered; full frame available
- clr_cmd_rdy  input  1  handler acknowledges frame
- send_resp  input  1  request to transmit resp
- resp  input  8  response byte
- trmt  output  1  registered; 1-cycle start pulse to UART transmitter
- tx_data  output  8  registered; byte presented to UART transmitter
- tx_done  input  1  UART transmitter finished its byte
- resp_sent  output  1  registered; 1-cycle pulse when response transmission completes
- frame_err  output  1  registered; 1-cycle pulse on inter-byte timeout

Behaviour:
- Reset (async, rst_n low):
  - All outputs, cmd, data, and the high-byte holding register go to 0.
  - Both FSMs go to their idle states.
  - Reset mid-frame discards the partial frame; reset mid-transmit drops trmt and produces no resp_sent.
- RX FSM states: IDLE, WAIT_HIGH, WAIT_LOW.
  - In any state with rx_rdy=1: clr_rx_rdy=1 in that same cycle; byte is captured on that clock edge.
  - With rx_rdy=0: clr_rx_rdy=0.
  - IDLE + rx_rdy: cmd <= rx_data; cmd_rdy <= 0; go to WAIT_HIGH.
  - WAIT_HIGH + rx_rdy: high_hold <= rx_data; go to WAIT_LOW.
  - WAIT_LOW + rx_rdy: data <= {high_hold, rx_data}; cmd_rdy <= 1; go to IDLE. cmd_rdy is visible 1 cycle after the low-byte edge.
  - data changes only on low-byte capture, so data and cmd are stable whenever cmd_rdy=1.
- cmd_rdy:
  - Cleared by clr_cmd_rdy, or by capture of a new cmd byte.
  - If clr_cmd_rdy and the frame-completing capture occur in the same cycle, set wins (cmd_rdy=1).
  - A frame overrunning an unacknowledged one overwrites it; no error is flagged.
- TX FSM states: TX_IDLE, TX_BUSY; independent of the RX FSM, and both may run simultaneously.
  - TX_IDLE + send_resp: tx_data <= resp; trmt <= 1 for exactly 1 cycle; go to TX_BUSY.
  - TX_BUSY + tx_done: resp_sent <= 1 for 1 cycle; go to TX_IDLE.
  - send_resp in TX_BUSY is ignored (not queued).
  - tx_data holds its value until the next accepted send_resp.
- Without FRAME_TIMEOUT_EN, frame_err is constant 0.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- When defined:
  - Counter of width $clog2(TIMEOUT_CYCLES) clears on every captured byte and in IDLE.
  - Counter increments each cycle in WAIT_HIGH/WAIT_LOW while rx_rdy=0.
  - On reaching TIMEOUT_CYCLES-1: RX FSM goes to IDLE, partial frame discarded, cmd_rdy unchanged, frame_err pulses 1 cycle.
  - If rx_rdy=1 in the terminal-count cycle, the byte wins: normal capture, no timeout.
- When undefined: no counter logic, frame_err tied 0, TIMEOUT_CYCLES unused; the FSM may wait indefinitely.

Test Plan:
- Reset, then bytes 0x05, 0xAB, 0xCD, each presented for 1 cycle with gaps -> clr_rx_rdy=1 on each presentation cycle; cmd_rdy=1 one cycle after 0xCD; cmd=0x05, data=0xABCD; outputs hold until clr_cmd_rdy, which clears cmd_rdy next cycle.
- With cmd_rdy=1 from frame 0x05/0xABCD, send 0x06, 0x12, 0x34 -> cmd_rdy drops on the 0x06 capture; data stays 0xABCD until 0x34; then cmd_rdy=1, data=0x1234. Assert clr_cmd_rdy on the 0x34 capture cycle -> cmd_rdy=1 (set wins).
- send_resp=1, resp=0xA5 -> trmt high exactly 1 cycle, tx_data=0xA5; second send_resp=0x5A while busy is ignored; tx_done -> resp_sent 1-cycle pulse, tx_data still 0xA5.
- Receive a full frame while a response is in TX_BUSY -> both completions are correct and independent.
- FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=64: send 0x07, 0x11, then silence -> frame_err pulses 64 cycles after 0x11 capture, cmd_rdy stays 0; next bytes 0x08, 0x22, 0x33 yield cmd=0x08, data=0x2233.
- Assert rst_n low after 0x09, 0x44 and mid-TX_BUSY -> all outputs 0 immediately; post-reset frame 0x01, 0x00, 0x01 yields cmd=0x01, data=0x0001; the old transmit produces no resp_sent.

Source files
------------

// File: rtl/comm_frame_rx_if.sv
// Byte-level handshake bundle between the UART pair, the deframer and the command handler.
// No logic, so no latency.
// Handshakes only: rx_rdy/clr_rx_rdy on receive, cmd_rdy/clr_cmd_rdy toward the handler, send_resp/tx_done on transmit.
interface comm_frame_rx_if;
    // UART receiver side
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    // command handler side
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    // UART transmitter side
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_sent;
    logic        frame_err;

    // environment: UART pair plus command handler
    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
        input  clr_rx_rdy, cmd, data, cmd_rdy, trmt, tx_data, resp_sent, frame_err
    );

    // the deframer itself
    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
        output clr_rx_rdy, cmd, data, cmd_rdy, trmt, tx_data, resp_sent, frame_err
    );
endinterface

// File: rtl/comm_frame_rx.sv
// Command deframer: folds 3 received bytes (cmd, data hi, data lo) into cmd/data and returns a 1-byte response.
// Latency: clr_rx_rdy same cycle as rx_rdy; cmd_rdy 1 cycle after the low byte; trmt 1 cycle after send_resp.
// Backpressure: none on receive (every byte is consumed at once, an unacknowledged frame is overwritten); send_resp is dropped while busy.
// Optional inter-byte timeout is built only when FRAME_TIMEOUT_EN is defined.
module comm_frame_rx #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            rst_n,
    comm_frame_rx_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT_HIGH, WAIT_LOW} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_BUSY}          tx_state_t;

    rx_state_t   rx_state, rx_state_nxt;
    tx_state_t   tx_state, tx_state_nxt;

    logic        clr_rx_rdy_c;
    logic        cap_cmd, cap_high, cap_low;
    logic        timeout_hit;
    logic        tx_start, tx_finish;

    logic [7:0]  cmd_q;
    logic [7:0]  high_hold;
    logic [15:0] data_q;
    logic        cmd_rdy_q;
    logic        trmt_q;
    logic [7:0]  tx_data_q;
    logic        resp_sent_q;
    logic        frame_err_q;

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= IDLE;
        else        rx_state <= rx_state_nxt;
    end

    // RX next state: advance on every byte, fall back to IDLE on timeout
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            IDLE:      if (bus.rx_rdy) rx_state_nxt = WAIT_HIGH;
            WAIT_HIGH: if (bus.rx_rdy) rx_state_nxt = WAIT_LOW;
                       else if (timeout_hit) rx_state_nxt = IDLE;
            WAIT_LOW:  if (bus.rx_rdy) rx_state_nxt = IDLE;
                       else if (timeout_hit) rx_state_nxt = IDLE;
            default:   rx_state_nxt = IDLE;
        endcase
    end

    // RX outputs: every presented byte is consumed immediately, capture strobe picks the field
    always_comb begin
        clr_rx_rdy_c = bus.rx_rdy;
        cap_cmd      = bus.rx_rdy && (rx_state == IDLE);
        cap_high     = bus.rx_rdy && (rx_state == WAIT_HIGH);
        cap_low      = bus.rx_rdy && (rx_state == WAIT_LOW);
    end

`ifdef FRAME_TIMEOUT_EN
    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;

    // a byte arriving on the terminal-count cycle wins over the timeout
    assign timeout_hit = (rx_state != IDLE) && !bus.rx_rdy && (to_cnt == CNT_LAST);

    // inter-byte gap counter, held at zero outside a frame and restarted by each byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if ((rx_state == IDLE) || bus.rx_rdy || timeout_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    // one-cycle error pulse when a partial frame is abandoned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err_q <= 1'b0;
        else        frame_err_q <= timeout_hit;
    end
`else
    // the limit only matters in the timeout build
    wire unused_timeout_cfg = |TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign frame_err_q = 1'b0;
`endif

    // frame datapath; data only moves on the low byte so cmd/data are stable while cmd_rdy is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= 8'h00;
            high_hold <= 8'h00;
            data_q    <= 16'h0000;
            cmd_rdy_q <= 1'b0;
        end else begin
            if (cap_cmd)  cmd_q     <= bus.rx_data;
            if (cap_high) high_hold <= bus.rx_data;
            if (cap_low)  data_q    <= {high_hold, bus.rx_data};
            // frame completion beats a same-cycle acknowledge
            if (cap_low)
                cmd_rdy_q <= 1'b1;
            else if (cap_cmd || bus.clr_cmd_rdy)
                cmd_rdy_q <= 1'b0;
        end
    end

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_nxt;
    end

    // TX next state: one response in flight, requests while busy are dropped
    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE: if (bus.send_resp) tx_state_nxt = TX_BUSY;
            TX_BUSY: if (bus.tx_done)   tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX outputs: start and finish strobes for the registered pulses below
    always_comb begin
        tx_start  = (tx_state == TX_IDLE) && bus.send_resp;
        tx_finish = (tx_state == TX_BUSY) && bus.tx_done;
    end

    // registered transmitter handshake; tx_data holds until the next accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trmt_q      <= 1'b0;
            tx_data_q   <= 8'h00;
            resp_sent_q <= 1'b0;
        end else begin
            trmt_q      <= tx_start;
            resp_sent_q <= tx_finish;
            if (tx_start) tx_data_q <= bus.resp;
        end
    end

    assign bus.clr_rx_rdy = clr_rx_rdy_c;
    assign bus.cmd        = cmd_q;
    assign bus.data       = data_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.trmt       = trmt_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.resp_sent  = resp_sent_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_comm_frame_rx.sv
// Directed bench for comm_frame_rx: framing, overrun, set-wins, response path, concurrency, timeout and reset.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// The timeout scenario follows FRAME_TIMEOUT_EN, with TIMEOUT_CYCLES fixed at 64.
module tb_comm_frame_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    comm_frame_rx_if bus();

    comm_frame_rx #(.TIMEOUT_CYCLES(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one byte for exactly one cycle
    task automatic put_byte(input logic [7:0] b);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        step();
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.cmd_rdy !== 1'b0)    begin failures++; $display("FAIL rst_cmd_rdy got=%h exp=0", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 8'h00)       begin failures++; $display("FAIL rst_cmd got=%h exp=00", bus.cmd); end
        checks++; if (bus.data !== 16'h0000)   begin failures++; $display("FAIL rst_data got=%h exp=0000", bus.data); end
        checks++; if (bus.trmt !== 1'b0)       begin failures++; $display("FAIL rst_trmt got=%h exp=0", bus.trmt); end
        checks++; if (bus.tx_data !== 8'h00)   begin failures++; $display("FAIL rst_tx_data got=%h exp=00", bus.tx_data); end
        checks++; if (bus.resp_sent !== 1'b0)  begin failures++; $display("FAIL rst_resp_sent got=%h exp=0", bus.resp_sent); end
        checks++; if (bus.frame_err !== 1'b0)  begin failures++; $display("FAIL rst_frame_err got=%h exp=0", bus.frame_err); end
        checks++; if (bus.clr_rx_rdy !== 1'b0) begin failures++; $display("FAIL rst_clr_rx_rdy got=%h exp=0", bus.clr_rx_rdy); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_frame();
        bus.rx_rdy = 1'b1; bus.rx_data = 8'h05; #1;
        checks++; if (bus.clr_rx_rdy !== 1'b1) begin failures++; $display("FAIL clr_on_cmd got=%h exp=1", bus.clr_rx_rdy); end
        step();
        bus.rx_rdy = 1'b0; #1;
        checks++; if (bus.clr_rx_rdy !== 1'b0) begin failures++; $display("FAIL clr_in_gap got=%h exp=0", bus.clr_rx_rdy); end
        checks++; if (bus.cmd !== 8'h05)       begin failures++; $display("FAIL cmd_capture got=%h exp=05", bus.cmd); end
        step(); step();
        bus.rx_rdy = 1'b1; bus.rx_data = 8'hAB; #1;
        checks++; if (bus.clr_rx_rdy !== 1'b1) begin failures++; $display("FAIL clr_on_high got=%h exp=1", bus.clr_rx_rdy); end
        step();
        bus.rx_rdy = 1'b0;
        step(); step();
        bus.rx_rdy = 1'b1; bus.rx_data = 8'hCD; #1;
        checks++; if (bus.clr_rx_rdy !== 1'b1) begin failures++; $display("FAIL clr_on_low got=%h exp=1", bus.clr_rx_rdy); end
        checks++; if (bus.cmd_rdy !== 1'b0)    begin failures++; $display("FAIL rdy_before_low got=%h exp=0", bus.cmd_rdy); end
        step();
        bus.rx_rdy = 1'b0;
        checks++; if (bus.cmd_rdy !== 1'b1)    begin failures++; $display("FAIL frame_rdy got=%h exp=1", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 8'h05)       begin failures++; $display("FAIL frame_cmd got=%h exp=05", bus.cmd); end
        checks++; if (bus.data !== 16'hABCD)   begin failures++; $display("FAIL frame_data got=%h exp=abcd", bus.data); end
        repeat (3) step();
        checks++; if (bus.cmd_rdy !== 1'b1)    begin failures++; $display("FAIL frame_hold_rdy got=%h exp=1", bus.cmd_rdy); end
        checks++; if (bus.data !== 16'hABCD)   begin failures++; $display("FAIL frame_hold_data got=%h exp=abcd", bus.data); end
    endtask

    task automatic test_overrun();
        put_byte(8'h06);
        checks++; if (bus.cmd_rdy !== 1'b0)    begin failures++; $display("FAIL ovr_rdy_drop got=%h exp=0", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 8'h06)       begin failures++; $display("FAIL ovr_cmd got=%h exp=06", bus.cmd); end
        checks++; if (bus.data !== 16'hABCD)   begin failures++; $display("FAIL ovr_data_after_cmd got=%h exp=abcd", bus.data); end
        put_byte(8'h12);
        checks++; if (bus.data !== 16'hABCD)   begin failures++; $display("FAIL ovr_data_after_high got=%h exp=abcd", bus.data); end
        bus.clr_cmd_rdy = 1'b1;
        put_byte(8'h34);
        bus.clr_cmd_rdy = 1'b0;
        checks++; if (bus.cmd_rdy !== 1'b1)    begin failures++; $display("FAIL set_wins_rdy got=%h exp=1", bus.cmd_rdy); end
        checks++; if (bus.data !== 16'h1234)   begin failures++; $display("FAIL ovr_data got=%h exp=1234", bus.data); end
        step();
        checks++; if (bus.cmd_rdy !== 1'b1)    begin failures++; $display("FAIL set_wins_hold got=%h exp=1", bus.cmd_rdy); end
    endtask

    task automatic test_ack();
        bus.clr_cmd_rdy = 1'b1;
        step();
        bus.clr_cmd_rdy = 1'b0;
        checks++; if (bus.cmd_rdy !== 1'b0)    begin failures++; $display("FAIL ack_rdy got=%h exp=0", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 8'h06)       begin failures++; $display("FAIL ack_cmd_kept got=%h exp=06", bus.cmd); end
        checks++; if (bus.data !== 16'h1234)   begin failures++; $display("FAIL ack_data_kept got=%h exp=1234", bus.data); end
    endtask

    task automatic test_tx();
        bus.send_resp = 1'b1; bus.resp = 8'hA5;
        step();
        bus.send_resp = 1'b0; bus.resp = 8'h00;
        checks++; if (bus.trmt !== 1'b1)       begin failures++; $display("FAIL tx_trmt_on got=%h exp=1", bus.trmt); end
        checks++; if (bus.tx_data !== 8'hA5)   begin failures++; $display("FAIL tx_data got=%h exp=a5", bus.tx_data); end
        step();
        checks++; if (bus.trmt !== 1'b0)       begin failures++; $display("FAIL tx_trmt_off got=%h exp=0", bus.trmt); end
        bus.send_resp = 1'b1; bus.resp = 8'h5A;
        step();
        bus.send_resp = 1'b0; bus.resp = 8'h00;
        checks++; if (bus.trmt !== 1'b0)       begin failures++; $display("FAIL tx_busy_trmt got=%h exp=0", bus.trmt); end
        checks++; if (bus.tx_data !== 8'hA5)   begin failures++; $display("FAIL tx_busy_data got=%h exp=a5", bus.tx_data); end
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        checks++; if (bus.resp_sent !== 1'b1)  begin failures++; $display("FAIL tx_resp_sent got=%h exp=1", bus.resp_sent); end
        step();
        checks++; if (bus.resp_sent !== 1'b0)  begin failures++; $display("FAIL tx_resp_sent_pulse got=%h exp=0", bus.resp_sent); end
        checks++; if (bus.tx_data !== 8'hA5)   begin failures++; $display("FAIL tx_data_hold got=%h exp=a5", bus.tx_data); end
    endtask

    task automatic test_concurrent();
        bus.send_resp = 1'b1; bus.resp = 8'h3C;
        step();
        bus.send_resp = 1'b0;
        checks++; if (bus.trmt !== 1'b1)       begin failures++; $display("FAIL cc_trmt got=%h exp=1", bus.trmt); end
        put_byte(8'h0A);
        put_byte(8'h0B);
        put_byte(8'h0C);
        checks++; if (bus.cmd_rdy !== 1'b1)    begin failures++; $display("FAIL cc_rdy got=%h exp=1", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 8'h0A)       begin failures++; $display("FAIL cc_cmd got=%h exp=0a", bus.cmd); end
        checks++; if (bus.data !== 16'h0B0C)   begin failures++; $display("FAIL cc_data got=%h exp=0b0c", bus.data); end
        checks++; if (bus.resp_sent !== 1'b0)  begin failures++; $display("FAIL cc_no_early_sent got=%h exp=0", bus.resp_sent); end
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        checks++; if (bus.resp_sent !== 1'b1)  begin failures++; $display("FAIL cc_resp_sent got=%h exp=1", bus.resp_sent); end
        checks++; if (bus.tx_data !== 8'h3C)   begin failures++; $display("FAIL cc_tx_data got=%h exp=3c", bus.tx_data); end
        checks++; if (bus.cmd_rdy !== 1'b1)    begin failures++; $display("FAIL cc_rdy_kept got=%h exp=1", bus.cmd_rdy); end
        bus.clr_cmd_rdy = 1'b1;
        step();
        bus.clr_cmd_rdy = 1'b0;
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        put_byte(8'h07);
        put_byte(8'h11);
        repeat (63) step();
        checks++; if (bus.frame_err !== 1'b0)  begin failures++; $display("FAIL to_early got=%h exp=0", bus.frame_err); end
        step();
        checks++; if (bus.frame_err !== 1'b1)  begin failures++; $display("FAIL to_pulse got=%h exp=1", bus.frame_err); end
        checks++; if (bus.cmd_rdy !== 1'b0)    begin failures++; $display("FAIL to_rdy got=%h exp=0", bus.cmd_rdy); end
        step();
        checks++; if (bus.frame_err !== 1'b0)  begin failures++; $display("FAIL to_pulse_end got=%h exp=0", bus.frame_err); end
        put_byte(8'h08);
        put_byte(8'h22);
        put_byte(8'h33);
        checks++; if (bus.cmd_rdy !== 1'b1)    begin failures++; $display("FAIL to_next_rdy got=%h exp=1", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 8'h08)       begin failures++; $display("FAIL to_next_cmd got=%h exp=08", bus.cmd); end
        checks++; if (bus.data !== 16'h2233)   begin failures++; $display("FAIL to_next_data got=%h exp=2233", bus.data); end
        bus.clr_cmd_rdy = 1'b1;
        step();
        bus.clr_cmd_rdy = 1'b0;
    endtask
`else
    task automatic test_timeout();
        put_byte(8'h07);
        put_byte(8'h11);
        repeat (200) step();
        checks++; if (bus.frame_err !== 1'b0)  begin failures++; $display("FAIL nto_frame_err got=%h exp=0", bus.frame_err); end
        checks++; if (bus.cmd_rdy !== 1'b0)    begin failures++; $display("FAIL nto_rdy_wait got=%h exp=0", bus.cmd_rdy); end
        put_byte(8'h33);
        checks++; if (bus.cmd_rdy !== 1'b1)    begin failures++; $display("FAIL nto_rdy got=%h exp=1", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 8'h07)       begin failures++; $display("FAIL nto_cmd got=%h exp=07", bus.cmd); end
        checks++; if (bus.data !== 16'h1133)   begin failures++; $display("FAIL nto_data got=%h exp=1133", bus.data); end
        bus.clr_cmd_rdy = 1'b1;
        step();
        bus.clr_cmd_rdy = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        put_byte(8'h09);
        put_byte(8'h44);
        bus.send_resp = 1'b1; bus.resp = 8'h77;
        step();
        bus.send_resp = 1'b0; bus.resp = 8'h00;
        checks++; if (bus.trmt !== 1'b1)       begin failures++; $display("FAIL rm_trmt_pre got=%h exp=1", bus.trmt); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.trmt !== 1'b0)       begin failures++; $display("FAIL rm_trmt got=%h exp=0", bus.trmt); end
        checks++; if (bus.tx_data !== 8'h00)   begin failures++; $display("FAIL rm_tx_data got=%h exp=00", bus.tx_data); end
        checks++; if (bus.cmd !== 8'h00)       begin failures++; $display("FAIL rm_cmd got=%h exp=00", bus.cmd); end
        checks++; if (bus.data !== 16'h0000)   begin failures++; $display("FAIL rm_data got=%h exp=0000", bus.data); end
        step();
        rst_n = 1'b1;
        step();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        checks++; if (bus.resp_sent !== 1'b0)  begin failures++; $display("FAIL rm_no_resp_sent got=%h exp=0", bus.resp_sent); end
        put_byte(8'h01);
        put_byte(8'h00);
        checks++; if (bus.cmd_rdy !== 1'b0)    begin failures++; $display("FAIL rm_partial_rdy got=%h exp=0", bus.cmd_rdy); end
        put_byte(8'h01);
        checks++; if (bus.cmd_rdy !== 1'b1)    begin failures++; $display("FAIL rm_rdy got=%h exp=1", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 8'h01)       begin failures++; $display("FAIL rm_cmd_new got=%h exp=01", bus.cmd); end
        checks++; if (bus.data !== 16'h0001)   begin failures++; $display("FAIL rm_data_new got=%h exp=0001", bus.data); end
    endtask

    initial begin
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = 8'h00;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.resp        = 8'h00;
        bus.tx_done     = 1'b0;
        test_reset();
        test_frame();
        test_overrun();
        test_ack();
        test_tx();
        test_concurrent();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
